fifo_out_drain: RTL and testbench

Read-side controller for the MAC output-data FIFO. It watches the FIFO's per-slot `ReadyM` flags and head data `DataOut2`, and issues `Pop2`. It forwards results downstream as fixed-length bursts over a registered valid/ready handshake. A sticky flush request drains any partial remainder.

---
 rtl/mac_fifo_pkg.sv | 16 +
 rtl/fifo_out_drain_if.sv | 29 ++
 rtl/Pointer.sv | 24 ++
 rtl/ready_count.sv | 18 +
 rtl/fifo_out_drain.sv | 145 ++++++++++++++
 tb/tb_fifo_out_drain.sv | 229 ++++++++++++++++++++++
 6 files changed

// File: rtl/mac_fifo_pkg.sv
// Shared definitions for the MAC output-FIFO read side: FSM states and
// default FIFO geometry.
package mac_fifo_pkg;

    localparam int DATA_WIDTH   = 32;
    localparam int BUFFER_WIDTH = 2;
    localparam int BUFFER_SIZE  = 2 ** BUFFER_WIDTH;
    localparam int COUNT_WIDTH  = BUFFER_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        FLUSH = 2'd2
    } drain_state_e;

endpackage

// File: rtl/fifo_out_drain_if.sv
// Bundle of the FIFO-side read signals, the downstream beat handshake and
// the flush request/acknowledge. master = drain controller, slave = its
// environment (FIFO plus downstream consumer).
interface fifo_out_drain_if #(
    parameter int DataWidth  = mac_fifo_pkg::DATA_WIDTH,
    parameter int BufferSize = mac_fifo_pkg::BUFFER_SIZE
) ();

    logic [BufferSize-1:0] ReadyM;
    logic [DataWidth-1:0]  DataOut2;
    logic                  Pop2;
    logic                  FlushReq;
    logic                  OutValid;
    logic [DataWidth-1:0]  OutData;
    logic                  OutLast;
    logic                  OutReady;
    logic                  FlushDone;

    modport master (
        input  ReadyM, DataOut2, FlushReq, OutReady,
        output Pop2, OutValid, OutData, OutLast, FlushDone
    );

    modport slave (
        output ReadyM, DataOut2, FlushReq, OutReady,
        input  Pop2, OutValid, OutData, OutLast, FlushDone
    );

endinterface

// File: rtl/Pointer.sv
// Wrapping FIFO pointer; advances by one on each enable.
module Pointer #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             EN,
    output logic [WIDTH-1:0] Ptr
);

    logic [WIDTH-1:0] ptr_q;

    // Increment on enable; wraps naturally from all-ones back to zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q <= '0;
        end else if (EN) begin
            ptr_q <= ptr_q + WIDTH'(1);
        end
    end

    assign Ptr = ptr_q;

endmodule

// File: rtl/ready_count.sv
// Combinational population count of the FIFO per-slot valid flags.
module ready_count #(
    parameter int N  = 4,
    parameter int CW = 3
) (
    input  logic [N-1:0]  ReadyM,
    output logic [CW-1:0] Count
);

    // Sum the valid flags into a CW-bit occupancy.
    always_comb begin
        Count = '0;
        for (int i = 0; i < N; i++) begin
            Count = Count + CW'(ReadyM[i]);
        end
    end

endmodule

// File: rtl/fifo_out_drain.sv
// Read-side controller for the MAC output FIFO: pops fixed-length bursts
// once enough words are present, drains a partial remainder on a sticky
// flush request, and presents each word on a registered valid/ready port.
module fifo_out_drain
    import mac_fifo_pkg::*;
#(
    parameter int DataWidth   = DATA_WIDTH,
    parameter int BufferWidth = BUFFER_WIDTH,
    parameter int BufferSize  = BUFFER_SIZE,
    parameter int BurstLen    = 2
) (
    input  logic            clk,
    input  logic            rst,
    fifo_out_drain_if.master bus
);

    localparam int CW = BufferWidth + 1;
    localparam logic [CW-1:0] BURST_LEN_C = CW'(BurstLen);

    drain_state_e         state_q, state_d;
    logic [BufferWidth-1:0] rd_ptr;
    logic [CW-1:0]        occ;
    logic [CW-1:0]        remain_q, remain_d;
    logic                 flush_pend_q, flush_pend_d;
    logic                 out_valid_q, out_last_q, flush_beat_q, flush_done_q;
    logic [DataWidth-1:0] out_data_q;
    logic                 head_valid, slot_free, pop;
    logic                 start_burst, start_flush, empty_flush, flush_accepted;

    ready_count #(.N(BufferSize), .CW(CW)) u_ready_count (
        .ReadyM (bus.ReadyM),
        .Count  (occ)
    );

    // Mirror of the FIFO head pointer; both reset together so they agree.
    Pointer #(.WIDTH(BufferWidth)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .EN  (pop),
        .Ptr (rd_ptr)
    );

    assign head_valid = bus.ReadyM[rd_ptr];
    assign slot_free  = ~out_valid_q | bus.OutReady;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a full burst wins over a pending flush; an empty flush
    // completes in place without leaving IDLE.
    always_comb begin
        state_d     = state_q;
        start_burst = 1'b0;
        start_flush = 1'b0;
        empty_flush = 1'b0;
        case (state_q)
            IDLE: begin
                if (occ >= BURST_LEN_C) begin
                    state_d     = BURST;
                    start_burst = 1'b1;
                end else if (flush_pend_q && occ != '0) begin
                    state_d     = FLUSH;
                    start_flush = 1'b1;
                end else if (flush_pend_q) begin
                    empty_flush = 1'b1;
                end
            end
            BURST, FLUSH: begin
                if (pop && remain_q == CW'(1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pop only a valid head into a free output slot while beats remain;
    // gated by reset so nothing leaves the FIFO while it is being cleared.
    always_comb begin
        pop = rst && (state_q != IDLE) && head_valid && slot_free
              && (remain_q != '0);
    end

    assign flush_accepted = out_valid_q & bus.OutReady & out_last_q & flush_beat_q;

    // Beat budget and sticky flush request; a new request in the same cycle
    // as a clear is kept so it is not lost.
    always_comb begin
        remain_d = remain_q;
        if (start_burst) begin
            remain_d = BURST_LEN_C;
        end else if (start_flush) begin
            remain_d = occ;
        end else if (pop) begin
            remain_d = remain_q - CW'(1);
        end
        flush_pend_d = (flush_pend_q & ~(start_flush | empty_flush)) | bus.FlushReq;
    end

    // Control registers for the beat budget and flush request.
    always_ff @(posedge clk) begin
        if (!rst) begin
            remain_q     <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            remain_q     <= remain_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    // Output beat register: load on pop, drop valid once accepted; data and
    // last are held while the consumer stalls.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            flush_beat_q <= 1'b0;
            flush_done_q <= 1'b0;
        end else begin
            flush_done_q <= flush_accepted | empty_flush;
            if (pop) begin
                out_valid_q  <= 1'b1;
                out_data_q   <= bus.DataOut2;
                out_last_q   <= (remain_q == CW'(1));
                flush_beat_q <= (state_q == FLUSH);
            end else if (bus.OutReady) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.Pop2      = pop;
    assign bus.OutValid  = out_valid_q;
    assign bus.OutData   = out_data_q;
    assign bus.OutLast   = out_last_q;
    assign bus.FlushDone = flush_done_q;

endmodule

// File: tb/tb_fifo_out_drain.sv
// Directed bench for fifo_out_drain: a small FIFO model feeds ReadyM and
// DataOut2, cycle tables hold hand-computed outputs, and a scoreboard checks
// a long streaming run.
module tb_fifo_out_drain;

    logic        clk;
    logic        rst;
    logic        push;
    logic [31:0] wdata;

    int checks = 0;
    int errors = 0;

    fifo_out_drain_if bus ();

    fifo_out_drain #(.BurstLen(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO model: push/pop sampled on the rising edge, shares rst.
    logic [31:0] fmem [4];
    logic [3:0]  fvalid, fvalid_n;
    logic [1:0]  frp, fwp;

    always_comb begin
        fvalid_n = fvalid;
        if (bus.Pop2) fvalid_n[frp] = 1'b0;
        if (push)     fvalid_n[fwp] = 1'b1;
    end

    always @(posedge clk) begin
        if (!rst) begin
            fvalid <= '0;
            frp    <= '0;
            fwp    <= '0;
        end else begin
            fvalid <= fvalid_n;
            if (bus.Pop2) frp <= frp + 2'd1;
            if (push) begin
                fmem[fwp] <= wdata;
                fwp       <= fwp + 2'd1;
            end
        end
    end

    assign bus.ReadyM   = fvalid;
    assign bus.DataOut2 = fmem[frp];

    typedef struct {
        bit          rst_n;
        bit          push;
        logic [31:0] wdata;
        bit          ready;
        bit          freq;
        bit          pop;
        bit          valid;
        logic [31:0] data;
        bit          last;
        bit          done;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(bit r, bit p, logic [31:0] wd, bit rdy, bit fr,
                                bit ep, bit ev, logic [31:0] ed, bit el, bit edn);
        vec_t v;
        v.rst_n = r;  v.push = p;   v.wdata = wd; v.ready = rdy; v.freq = fr;
        v.pop   = ep; v.valid = ev; v.data  = ed; v.last  = el;  v.done = edn;
        return v;
    endfunction

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic run_table(input string tag);
        logic [35:0] act, exp;
        foreach (tv[i]) begin
            @(negedge clk);
            rst          = tv[i].rst_n;
            push         = tv[i].push;
            wdata        = tv[i].wdata;
            bus.OutReady = tv[i].ready;
            bus.FlushReq = tv[i].freq;
            #1;
            act = {bus.Pop2, bus.OutValid, bus.OutLast, bus.FlushDone, bus.OutData};
            exp = {tv[i].pop, tv[i].valid, tv[i].last, tv[i].done, tv[i].data};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL %s row %0d: got pop=%b valid=%b last=%b done=%b data=%h, want pop=%b valid=%b last=%b done=%b data=%h",
                         tag, i, act[35], act[34], act[33], act[32], act[31:0],
                         exp[35], exp[34], exp[33], exp[32], exp[31:0]);
            end else begin
                $display("%s row %0d: pop=%b valid=%b last=%b done=%b data=%h",
                         tag, i, act[35], act[34], act[33], act[32], act[31:0]);
            end
        end
        tv.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int pushed;
        int beats;

        rst          = 1'b0;
        push         = 1'b0;
        wdata        = '0;
        bus.OutReady = 1'b0;
        bus.FlushReq = 1'b0;

        // Reset values.
        repeat (3) @(negedge clk);
        #1;
        check_val("reset_pop",   32'(bus.Pop2),      32'd0);
        check_val("reset_valid", 32'(bus.OutValid),  32'd0);
        check_val("reset_data",  bus.OutData,        32'd0);
        check_val("reset_last",  32'(bus.OutLast),   32'd0);
        check_val("reset_done",  32'(bus.FlushDone), 32'd0);

        // Two-word burst A,B.
        tv.push_back(mk(1,1,32'hA,1,0, 0,0,32'h0,0,0));
        tv.push_back(mk(1,1,32'hB,1,0, 0,0,32'h0,0,0));
        tv.push_back(mk(1,0,32'h0,1,0, 0,0,32'h0,0,0));
        tv.push_back(mk(1,0,32'h0,1,0, 1,0,32'h0,0,0));
        tv.push_back(mk(1,0,32'h0,1,0, 1,1,32'hA,0,0));
        tv.push_back(mk(1,0,32'h0,1,0, 0,1,32'hB,1,0));
        tv.push_back(mk(1,0,32'h0,1,0, 0,0,32'hB,1,0));
        // Single word sits idle, then a flush drains it.
        tv.push_back(mk(1,1,32'h5,1,0, 0,0,32'hB,1,0));
        for (int k = 0; k < 10; k++) tv.push_back(mk(1,0,32'h0,1,0, 0,0,32'hB,1,0));
        tv.push_back(mk(1,0,32'h0,1,1, 0,0,32'hB,1,0));
        tv.push_back(mk(1,0,32'h0,1,0, 0,0,32'hB,1,0));
        tv.push_back(mk(1,0,32'h0,1,0, 1,0,32'hB,1,0));
        tv.push_back(mk(1,0,32'h0,1,0, 0,1,32'h5,1,0));
        tv.push_back(mk(1,0,32'h0,1,0, 0,0,32'h5,1,1));
        tv.push_back(mk(1,0,32'h0,1,0, 0,0,32'h5,1,0));
        // Fill with 1..4 under back-pressure, then release.
        tv.push_back(mk(1,1,32'h1,0,0, 0,0,32'h5,1,0));
        tv.push_back(mk(1,1,32'h2,0,0, 0,0,32'h5,1,0));
        tv.push_back(mk(1,1,32'h3,0,0, 0,0,32'h5,1,0));
        tv.push_back(mk(1,1,32'h4,0,0, 1,0,32'h5,1,0));
        for (int k = 0; k < 4; k++) tv.push_back(mk(1,0,32'h0,0,0, 0,1,32'h1,0,0));
        tv.push_back(mk(1,0,32'h0,1,0, 1,1,32'h1,0,0));
        tv.push_back(mk(1,0,32'h0,1,0, 0,1,32'h2,1,0));
        tv.push_back(mk(1,0,32'h0,1,0, 1,0,32'h2,1,0));
        tv.push_back(mk(1,0,32'h0,1,0, 1,1,32'h3,0,0));
        tv.push_back(mk(1,0,32'h0,1,0, 0,1,32'h4,1,0));
        tv.push_back(mk(1,0,32'h0,1,0, 0,0,32'h4,1,0));
        run_table("basic");

        // Streaming 12 words: push whenever the FIFO has room.
        pushed = 0;
        beats  = 0;
        for (int cyc = 0; cyc < 200 && beats < 12; cyc++) begin
            @(negedge clk);
            bus.OutReady = 1'b1;
            bus.FlushReq = 1'b0;
            if (pushed < 12 && $countones(fvalid) < 4) begin
                push  = 1'b1;
                wdata = 32'h10 + 32'(pushed);
                pushed++;
            end else begin
                push = 1'b0;
            end
            #1;
            if (bus.Pop2) check_val("stream_pop_head_valid", 32'(fvalid[frp]), 32'd1);
            if (bus.OutValid) begin
                check_val("stream_data", bus.OutData, 32'h10 + 32'(beats));
                check_val("stream_last", 32'(bus.OutLast), 32'(beats % 2));
                $display("stream beat %0d: data=%h last=%b", beats, bus.OutData, bus.OutLast);
                beats++;
            end
        end
        push = 1'b0;
        check_val("stream_beat_count", 32'(beats), 32'd12);

        // Empty flush.
        tv.push_back(mk(1,0,32'h0,1,1, 0,0,32'h1B,1,0));
        tv.push_back(mk(1,0,32'h0,1,0, 0,0,32'h1B,1,0));
        tv.push_back(mk(1,0,32'h0,1,0, 0,0,32'h1B,1,1));
        tv.push_back(mk(1,0,32'h0,1,0, 0,0,32'h1B,1,0));
        // Flush request during a burst: burst finishes, remainder drains.
        tv.push_back(mk(1,1,32'h21,1,0, 0,0,32'h1B,1,0));
        tv.push_back(mk(1,1,32'h22,1,0, 0,0,32'h1B,1,0));
        tv.push_back(mk(1,1,32'h23,1,0, 0,0,32'h1B,1,0));
        tv.push_back(mk(1,0,32'h0,1,1,  1,0,32'h1B,1,0));
        tv.push_back(mk(1,0,32'h0,1,0,  1,1,32'h21,0,0));
        tv.push_back(mk(1,0,32'h0,1,0,  0,1,32'h22,1,0));
        tv.push_back(mk(1,0,32'h0,1,0,  1,0,32'h22,1,0));
        tv.push_back(mk(1,0,32'h0,1,0,  0,1,32'h23,1,0));
        tv.push_back(mk(1,0,32'h0,1,0,  0,0,32'h23,1,1));
        tv.push_back(mk(1,0,32'h0,1,0,  0,0,32'h23,1,0));
        // Reset during the second beat, then a clean burst 7,8.
        tv.push_back(mk(1,1,32'h31,1,0, 0,0,32'h23,1,0));
        tv.push_back(mk(1,1,32'h32,1,0, 0,0,32'h23,1,0));
        tv.push_back(mk(1,0,32'h0,1,0,  0,0,32'h23,1,0));
        tv.push_back(mk(1,0,32'h0,1,0,  1,0,32'h23,1,0));
        tv.push_back(mk(0,0,32'h0,1,0,  0,1,32'h31,0,0));
        tv.push_back(mk(1,0,32'h0,1,0,  0,0,32'h0,0,0));
        tv.push_back(mk(1,1,32'h7,1,0,  0,0,32'h0,0,0));
        tv.push_back(mk(1,1,32'h8,1,0,  0,0,32'h0,0,0));
        tv.push_back(mk(1,0,32'h0,1,0,  0,0,32'h0,0,0));
        tv.push_back(mk(1,0,32'h0,1,0,  1,0,32'h0,0,0));
        tv.push_back(mk(1,0,32'h0,1,0,  1,1,32'h7,0,0));
        tv.push_back(mk(1,0,32'h0,1,0,  0,1,32'h8,1,0));
        tv.push_back(mk(1,0,32'h0,1,0,  0,0,32'h8,1,0));
        run_table("flush_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
